// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU benches: sequences core reset, counts cycles/retires, detects end of program.
// Optional retire/termination trace when CPU_RUN_TRACE_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     RST_CYCLES  = 4,
  parameter logic [PC_W-1:0] HALT_PC     = PC_W'(32'h0000_3ffc),
  parameter int unsigned     HALT_REPEAT = 3,
  parameter int unsigned     MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic [1:0]       reason,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SAME_W = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [SAME_W-1:0] SPIN_AT   = SAME_W'(HALT_REPEAT - 2);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  localparam logic [1:0] RSN_NONE = 2'b00;
  localparam logic [1:0] RSN_SPIN = 2'b01;
  localparam logic [1:0] RSN_HALT = 2'b10;
  localparam logic [1:0] RSN_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SAME_W-1:0] same_cnt;
  logic [PC_W-1:0]   last_pc;
  logic              same_pc_c;
  logic [1:0]        term_rsn_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Termination detect (halt PC > spin > timeout) and next-state
  always_comb begin
    state_nxt  = state;
    term_rsn_c = RSN_NONE;
    same_pc_c  = (pc == last_pc);
    if (pc_valid && (pc == HALT_PC))                      term_rsn_c = RSN_HALT;
    else if (pc_valid && same_pc_c && (same_cnt == SPIN_AT)) term_rsn_c = RSN_SPIN;
    else if (cycle_cnt == CYC_LAST)                       term_rsn_c = RSN_TMO;
    case (state)
      S_IDLE, S_DONE: if (start)                   state_nxt = S_RST_HOLD;
      S_RST_HOLD:     if (hold_cnt == HOLD_LAST)   state_nxt = S_RUN;
      S_RUN:          if (term_rsn_c != RSN_NONE)  state_nxt = S_DONE;
      default:                                     state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and run datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      reason     <= RSN_NONE;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      hold_cnt   <= '0;
      same_cnt   <= '0;
      last_pc    <= '0;
    end else begin
      cpu_reset <= (state_nxt != S_RUN);
      busy      <= (state_nxt == S_RST_HOLD) || (state_nxt == S_RUN);
      done      <= (state_nxt == S_DONE);
      if ((state != S_RST_HOLD) && (state_nxt == S_RST_HOLD)) begin
        reason     <= RSN_NONE;
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        hold_cnt   <= '0;
        same_cnt   <= '0;
        last_pc    <= '0;
      end else if (state == S_RST_HOLD) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else if (state == S_RUN) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (pc_valid) begin
          if (retire_cnt != '1) retire_cnt <= retire_cnt + CNT_W'(1);
          last_pc  <= pc;
          same_cnt <= (same_pc_c && (retire_cnt != '0)) ? same_cnt + SAME_W'(1) : '0;
        end
        if (state_nxt == S_DONE) reason <= term_rsn_c;
      end
    end
  end

`ifdef CPU_RUN_TRACE_EN
  // Simulation trace of retires and the final report
  always @(posedge clk) begin
    if (reset && (state == S_RUN)) begin
      if (pc_valid) $display("%d@%h", cycle_cnt, pc);
      if (state_nxt == S_DONE)
        $display("cpu_run_ctrl: reason=%b cycles=%0d retires=%0d", term_rsn_c,
                 cycle_cnt + CNT_W'(1),
                 (pc_valid && (retire_cnt != '1)) ? retire_cnt + CNT_W'(1) : retire_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected run reports, monitors check on done.
module tb_cpu_run_ctrl;

  localparam int unsigned RST_N = 4;

  logic        clk = 1'b0;
  logic        reset, start, start2, pc_valid;
  logic [31:0] pc;
  logic        cpu_reset, busy, done, cpu_reset2, busy2, done2;
  logic [1:0]  reason, reason2;
  logic [31:0] cycle_cnt, retire_cnt, cycle_cnt2, retire_cnt2;
  logic        done_d, done2_d;

  typedef struct {
    string       nm;
    logic [1:0]  rsn;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [31:0] pq[$];
  logic        vq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYCLES(RST_N), .HALT_PC(32'h0000_3ffc),
                 .HALT_REPEAT(3), .MAX_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .reason(reason),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));

  // Halt PC at 0 with HALT_REPEAT=2 lets halt and spin fire on the same retire
  cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_PC(32'h0000_0000),
                 .HALT_REPEAT(2), .MAX_CYCLES(8)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset2), .busy(busy2), .done(done2), .reason(reason2),
    .cycle_cnt(cycle_cnt2), .retire_cnt(retire_cnt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic sb_cmp(input exp_t e, input logic [1:0] r, input logic [31:0] c,
                        input logic [31:0] t);
    chk({e.nm, ".reason"}, 32'(r), 32'(e.rsn));
    chk({e.nm, ".cycle_cnt"}, c, e.cyc);
    chk({e.nm, ".retire_cnt"}, t, e.ret);
  endtask

  // Monitors: a rising done is the DUT presenting a run report
  always @(negedge clk) begin
    done_d <= done;
    if (done && !done_d) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else sb_cmp(exp_q.pop_front(), reason, cycle_cnt, retire_cnt);
    end
  end

  always @(negedge clk) begin
    done2_d <= done2;
    if (done2 && !done2_d) begin
      if (exp2_q.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
      else sb_cmp(exp2_q.pop_front(), reason2, cycle_cnt2, retire_cnt2);
    end
  end

  // Pulse start, check the cleared report and the exact reset-hold window
  task automatic do_start(input string nm);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, ".clr_cnt"}, cycle_cnt | retire_cnt, 32'd0);
    chk({nm, ".clr_reason"}, 32'(reason), 32'd0);
    for (int i = 0; i < int'(RST_N); i++) begin
      @(negedge clk);
      chk({nm, ".hold_cpu_reset"}, 32'(cpu_reset), 32'd1);
      chk({nm, ".hold_busy"}, 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    chk({nm, ".run_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({nm, ".run_done"}, 32'(done), 32'd0);
  endtask

  // Drive queued retires one per RUN cycle; optionally pulse start at index start_at
  task automatic feed(input int start_at);
    for (int i = 0; i < pq.size(); i++) begin
      pc = pq[i]; pc_valid = vq[i]; start = (i == start_at);
      @(posedge clk); #1;
    end
    pc_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1; k++;
    end
    if (!done) chk({nm, ".done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string nm, input logic [1:0] rsn, input int cyc, input int ret,
                     input int start_at);
    exp_q.push_back('{nm, rsn, 32'(cyc), 32'(ret)});
    do_start(nm);
    feed(start_at);
    wait_done(nm);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0; pc_valid = 1'b0; pc = '0;
    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst.busy_done", 32'({busy, done}), 32'd0);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle.busy_done", 32'({busy, done}), 32'd0);
    chk("idle.counters", cycle_cnt | retire_cnt, 32'd0);
    chk("idle.reason", 32'(reason), 32'd0);

    // Spin halt
    pq = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
    vq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run("spin", 2'b01, 5, 5, -1);

    // Halt PC, restarted from DONE
    pq = '{32'h3000, 32'h3004, 32'h3ffc};
    vq = '{1'b1, 1'b1, 1'b1};
    run("halt", 2'b10, 3, 3, -1);

    // Timeout with retires on alternate cycles
    pq = '{32'h100, 32'h104, 32'h108, 32'h10c, 32'h110, 32'h114, 32'h118, 32'h11c};
    vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    run("timeout", 2'b11, 8, 4, -1);

    // start during RUN is ignored; run still ends on spin
    pq = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h208};
    vq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run("start_in_run", 2'b01, 5, 5, 2);

    // Halt PC and spin on the same retire: halt wins
    exp2_q.push_back('{"halt_over_spin", 2'b10, 32'd1, 32'd1});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 pc = 32'h0; pc_valid = 1'b1;
    @(posedge clk); #1 pc_valid = 1'b0;
    for (int k = 0; k < 20 && !done2; k++) begin
      @(posedge clk); #1;
    end
    if (!done2) chk("halt_over_spin.done_timeout", 32'd0, 32'd1);

    // Abort in RUN cycle 3
    do_start("abort");
    pc = 32'h400; pc_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort.busy_done", 32'({busy, done}), 32'd0);
    chk("abort.counters", cycle_cnt | retire_cnt, 32'd0);
    chk("abort.reason", 32'(reason), 32'd0);
    pc_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort.idle", 32'({cpu_reset, busy, done}), 32'b100);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size() + exp2_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
